// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: FSM state encoding, default bit period and frame size.
// The receiver side is expected to import the same package.
package uart_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 217;  // 25 MHz / 115200 baud
  localparam int unsigned FRAME_BITS           = 10;   // start + 8 data + stop

endpackage

// File: rtl/uart_tx_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and pulses TICK on the terminal count.
// CLR restarts the period from zero on the next edge.
module baud_tick
  import uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic CLR,
  output logic TICK
);

  localparam int unsigned        CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]   TERM  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;

  assign TICK = (cnt_q == TERM);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else if (CLR || TICK) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, with a READY/LOAD byte handshake.
// TX and READY are registered from the next-state values so they change on the accepting edge.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] DATA,
  input  logic       LOAD,
  output logic       READY,
  output logic       TX
);

  uart_state_t state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_q, bit_d;
  logic        tx_q, tx_d;
  logic        ready_q;
  logic        tick;
  logic        clr;

  // Every state change restarts the bit period.
  assign clr = (state_d != state_q);

  baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .CLK  (CLK),
    .RST_N(RST_N),
    .CLR  (clr),
    .TICK (tick)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    case (state_q)
      ST_IDLE: begin
        if (LOAD) begin
          shift_d = DATA;
          bit_d   = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (tick) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      ready_q <= (state_d == ST_IDLE);
    end
  end

  assign TX    = tx_q;
  assign READY = ready_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx at CLKS_PER_BIT = 4, 2 and 217; a frame monitor decodes TX
// and checks each frame against a queue of expected frames.
module tb_uart_tx;
  import uart_tx_pkg::*;

  typedef struct {
    logic [1:0] s;
    logic [7:0] d;
    logic [9:0] f;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       load = 1'b0;
  logic [7:0] data = 8'h00;
  logic [1:0] sel = 2'd0;
  logic [2:0] ld, rdy, txv;
  logic       rdy_m, tx_m;

  int total = 0, bad = 0;
  int frames = 0, aborts = 0, cyc = 0, last_start = 0, prev_start = 0;
  logic [9:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign ld[0] = load && (sel == 2'd0);
  assign ld[1] = load && (sel == 2'd1);
  assign ld[2] = load && (sel == 2'd2);
  assign rdy_m = rdy[sel];
  assign tx_m  = txv[sel];

  uart_tx #(.CLKS_PER_BIT(4)) u_dut4 (
    .CLK(clk), .RST_N(rst_n), .DATA(data), .LOAD(ld[0]), .READY(rdy[0]), .TX(txv[0]));
  uart_tx #(.CLKS_PER_BIT(2)) u_dut2 (
    .CLK(clk), .RST_N(rst_n), .DATA(data), .LOAD(ld[1]), .READY(rdy[1]), .TX(txv[1]));
  uart_tx #(.CLKS_PER_BIT(217)) u_dut217 (
    .CLK(clk), .RST_N(rst_n), .DATA(data), .LOAD(ld[2]), .READY(rdy[2]), .TX(txv[2]));

  function automatic int cpb_of(input logic [1:0] s);
    case (s)
      2'd0:    return 4;
      2'd1:    return 2;
      default: return 217;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame monitor: every TX window must be constant with READY low, READY high right after.
  initial begin : monitor
    logic [9:0] bits, expf;
    bit timing_ok, aborted;
    int p;
    forever begin
      @(negedge clk);
      if (rst_n && tx_m === 1'b0) begin
        p = cpb_of(sel);
        bits = '0;
        timing_ok = 1'b1;
        aborted = 1'b0;
        prev_start = last_start;
        last_start = cyc;
        for (int w = 0; w < 10; w++) begin
          for (int c = 0; c < p; c++) begin
            if (!(w == 0 && c == 0)) @(negedge clk);
            if (!rst_n) begin
              aborted = 1'b1;
              break;
            end
            if (c == 0) bits[w] = tx_m;
            else if (tx_m !== bits[w]) timing_ok = 1'b0;
            if (rdy_m !== 1'b0) timing_ok = 1'b0;
          end
          if (aborted) break;
        end
        if (aborted) begin
          aborts++;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else begin
          @(negedge clk);
          chk("ready_after_stop", 32'(rdy_m), 32'(1'b1));
          chk("bit_timing", 32'(timing_ok), 32'(1'b1));
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_frame: got=%b want=none", bits);
          end else begin
            expf = exp_q.pop_front();
            chk("frame", 32'(bits), 32'(expf));
          end
          frames++;
        end
      end
    end
  end

  task automatic wait_ready(input int budget);
    int c = 0;
    while (rdy_m !== 1'b1 && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("ready_timeout", 32'(rdy_m), 32'(1'b1));
  endtask

  task automatic wait_frames(input int n, input int budget);
    int c = 0;
    while (frames < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("frame_timeout", 32'(frames >= n), 32'(1'b1));
  endtask

  task automatic send(input logic [1:0] s, input logic [7:0] d, input logic [9:0] f);
    sel = s;
    wait_ready(20 * cpb_of(s) + 20);
    @(negedge clk);
    data = d;
    load = 1'b1;
    exp_q.push_back(f);
    @(posedge clk);
    #1;
    load = 1'b0;
    chk("accept_ready_low", 32'(rdy_m), 32'(1'b0));
    chk("accept_start_bit", 32'(tx_m), 32'(1'b0));
  endtask

  initial begin : main
    vec_t tbl[7];
    logic [7:0] r1, r2;
    int badcyc, base, base_a;

    r1 = 8'($urandom_range(0, 255));
    r2 = 8'($urandom_range(0, 255));
    tbl[0] = '{2'd0, 8'h55, 10'b1_01010101_0};
    tbl[1] = '{2'd1, 8'h00, 10'b1_00000000_0};
    tbl[2] = '{2'd1, 8'hFF, 10'b1_11111111_0};
    tbl[3] = '{2'd1, r1,    {1'b1, r1, 1'b0}};
    tbl[4] = '{2'd2, 8'h00, 10'b1_00000000_0};
    tbl[5] = '{2'd2, 8'hFF, 10'b1_11111111_0};
    tbl[6] = '{2'd2, r2,    {1'b1, r2, 1'b0}};

    // Reset state, asynchronous, then 100 idle cycles.
    #3 rst_n = 1'b0;
    #1;
    chk("reset_tx", 32'(txv), 32'(3'b111));
    chk("reset_ready", 32'(rdy), 32'(3'b111));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    badcyc = 0;
    repeat (100) begin
      @(negedge clk);
      if (rdy !== 3'b111 || txv !== 3'b111) badcyc++;
    end
    chk("idle_100_cycles", 32'(badcyc), 32'(0));

    for (int i = 0; i < 7; i++) begin
      base = frames;
      send(tbl[i].s, tbl[i].d, tbl[i].f);
      wait_frames(base + 1, 12 * cpb_of(tbl[i].s) + 20);
    end

    // Back-to-back with LOAD held high: one idle cycle between frames.
    sel = 2'd0;
    wait_ready(100);
    base = frames;
    @(negedge clk);
    data = 8'hA3;
    load = 1'b1;
    exp_q.push_back(10'b1_10100011_0);
    exp_q.push_back(10'b1_00001111_0);
    @(posedge clk);
    #1 data = 8'h0F;
    wait_ready(100);
    @(posedge clk);
    #1 load = 1'b0;
    chk("b2b_second_accept", 32'(rdy_m), 32'(1'b0));
    wait_frames(base + 2, 120);
    chk("b2b_gap", 32'(last_start - prev_start), 32'(41));

    // LOAD while busy is ignored.
    base = frames;
    send(2'd0, 8'h00, 10'b1_00000000_0);
    repeat (9) @(negedge clk);
    data = 8'hFF;
    load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    wait_frames(base + 1, 80);
    repeat (60) @(negedge clk);
    chk("no_second_frame", 32'(frames), 32'(base + 1));
    chk("idle_after_ignored", 32'(rdy_m), 32'(1'b1));

    // Reset during data bit 3 of 0x81, then a clean frame.
    base_a = aborts;
    send(2'd0, 8'h81, 10'b1_10000001_0);
    repeat (17) @(posedge clk);
    #1;
    chk("bit3_before_reset", 32'(tx_m), 32'(1'b0));
    rst_n = 1'b0;
    #1;
    chk("midreset_tx", 32'(tx_m), 32'(1'b1));
    chk("midreset_ready", 32'(rdy_m), 32'(1'b1));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("frame_abandoned", 32'(aborts), 32'(base_a + 1));
    base = frames;
    send(2'd0, 8'h3C, 10'b1_00111100_0);
    wait_frames(base + 1, 80);

    repeat (5) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
